// File: rtl/traffic_sensor_conditioner.sv
// -----------------------------------------------------------------------------
// traffic_sensor_conditioner
//
// Conditions the two raw vehicle-sensor inputs that feed the traffic-light FSM.
// Each channel does four things:
//   - synchronizes its raw input through two flops
//   - debounces the level changes
//   - stretches presence for a hold period after a qualified release
//   - gives a one-cycle arrival pulse and a saturating arrival count
//
// Ports (top):
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-high reset, clears every flop
//   raw_a/b  in   raw Academic / Bravado sensors, asynchronous to clk
//   cnt_clr  in   synchronous clear of both arrival counters
//   TA/TB    out  conditioned presence, decoded from state only
//   arr_a/b  out  registered one-cycle arrival pulses
//   cnt_a/b  out  CW-bit saturating arrival counts
// -----------------------------------------------------------------------------

// One conditioning channel. The top module instantiates two identical copies.
module traffic_sensor_conditioner_ch #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 8,
  parameter int CW              = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          raw,
  input  logic          cnt_clr,
  output logic          t,
  output logic          arr,
  output logic [CW-1:0] cnt
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  localparam logic [DW-1:0] DEB_ONE   = DW'(1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

  typedef enum logic [2:0] {
    IDLE,
    QUAL_ON,
    PRESENT,
    QUAL_OFF,
    HOLD
  } state_t;

  state_t        state_q, state_d;
  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic [DW-1:0] deb_q, deb_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          arr_q, arr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          arrival;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    s1_d    = raw;
    s2_d    = s1_q;
    state_d = state_q;
    deb_d   = deb_q;
    hold_d  = hold_q;
    arrival = 1'b0;

    // The run counter holds the number of matching samples already accepted
    // in a QUAL state. A state is left on its DEBOUNCE_CYCLES-th sample, so
    // the comparison is against DEBOUNCE_CYCLES-1.
    unique case (state_q)
      IDLE: begin
        if (s2_q) begin
          state_d = QUAL_ON;
          deb_d   = DEB_ONE;
        end
      end
      QUAL_ON: begin
        if (!s2_q) begin
          state_d = IDLE;
          deb_d   = '0;
        end else if (deb_q == DEB_LAST) begin
          state_d = PRESENT;
          deb_d   = '0;
          arrival = 1'b1;
        end else begin
          deb_d = deb_q + DEB_ONE;
        end
      end
      PRESENT: begin
        if (!s2_q) begin
          state_d = QUAL_OFF;
          deb_d   = DEB_ONE;
        end
      end
      QUAL_OFF: begin
        if (s2_q) begin
          state_d = PRESENT;
          deb_d   = '0;
        end else if (deb_q == DEB_LAST) begin
          state_d = HOLD;
          deb_d   = '0;
          hold_d  = '0;
        end else begin
          deb_d = deb_q + DEB_ONE;
        end
      end
      HOLD: begin
        // A return of the sensor during hold is the same occupancy: no arrival.
        if (s2_q) begin
          state_d = PRESENT;
          hold_d  = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d = IDLE;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + HOLD_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        deb_d   = '0;
        hold_d  = '0;
      end
    endcase

    arr_d = arrival;

    // A clear that coincides with an arrival still records that arrival.
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = arrival ? CNT_ONE : '0;
    end else if (arrival && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // NOTE: state registers use non-blocking assignments so that all flops
  // sample their pre-edge values, exactly like the hardware.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= IDLE;
      deb_q   <= '0;
      hold_q  <= '0;
      arr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      state_q <= state_d;
      deb_q   <= deb_d;
      hold_q  <= hold_d;
      arr_q   <= arr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign t   = (state_q == PRESENT) || (state_q == QUAL_OFF) || (state_q == HOLD);
  assign arr = arr_q;
  assign cnt = cnt_q;

endmodule

module traffic_sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 8,
  parameter int CW              = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          raw_a,
  input  logic          raw_b,
  input  logic          cnt_clr,
  output logic          TA,
  output logic          TB,
  output logic          arr_a,
  output logic          arr_b,
  output logic [CW-1:0] cnt_a,
  output logic [CW-1:0] cnt_b
);

  traffic_sensor_conditioner_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES),
    .CW             (CW)
  ) u_ch_a (
    .clk    (clk),
    .reset  (reset),
    .raw    (raw_a),
    .cnt_clr(cnt_clr),
    .t      (TA),
    .arr    (arr_a),
    .cnt    (cnt_a)
  );

  traffic_sensor_conditioner_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES),
    .CW             (CW)
  ) u_ch_b (
    .clk    (clk),
    .reset  (reset),
    .raw    (raw_b),
    .cnt_clr(cnt_clr),
    .t      (TB),
    .arr    (arr_b),
    .cnt    (cnt_b)
  );

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// -----------------------------------------------------------------------------
// tb_traffic_sensor_conditioner
//
// Bench for traffic_sensor_conditioner. It runs two instances on the same
// stimulus: one with default parameters, and one with CW=2 to exercise
// saturation. The reference model works on run lengths of the synchronized
// level:
//   - presence rises when a run of ones reaches DEBOUNCE_CYCLES
//   - presence falls when a run of zeros reaches DEBOUNCE_CYCLES+HOLD_CYCLES
// -----------------------------------------------------------------------------
module tb_traffic_sensor_conditioner;

  localparam int D = 4;
  localparam int H = 8;

  logic       clk;
  logic       rst;
  logic       raw_a, raw_b, cnt_clr;
  logic       TA, TB, arr_a, arr_b;
  logic [7:0] cnt_a, cnt_b;
  logic       ta2, tb2, arr_a2, arr_b2;
  logic [1:0] cnt_a2, cnt_b2;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  traffic_sensor_conditioner dut (
    .clk    (clk),
    .reset  (rst),
    .raw_a  (raw_a),
    .raw_b  (raw_b),
    .cnt_clr(cnt_clr),
    .TA     (TA),
    .TB     (TB),
    .arr_a  (arr_a),
    .arr_b  (arr_b),
    .cnt_a  (cnt_a),
    .cnt_b  (cnt_b)
  );

  traffic_sensor_conditioner #(.CW(2)) dut_w2 (
    .clk    (clk),
    .reset  (rst),
    .raw_a  (raw_a),
    .raw_b  (raw_b),
    .cnt_clr(cnt_clr),
    .TA     (ta2),
    .TB     (tb2),
    .arr_a  (arr_a2),
    .arr_b  (arr_b2),
    .cnt_a  (cnt_a2),
    .cnt_b  (cnt_b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and return at the following falling edge.
  task automatic step();
    @(posedge clk);
    edge_n++;
    @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  int sy1[2], sy2[2];       // two-stage delay of the raw inputs
  int ones[2], zeros[2];    // current run lengths of the synchronized level
  int pres[2], arrm[2];
  int cnt8m[2], cnt2m[2];
  int rawv[2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        sy1[c] = 0; sy2[c] = 0; ones[c] = 0; zeros[c] = 0;
        pres[c] = 0; arrm[c] = 0; cnt8m[c] = 0; cnt2m[c] = 0;
      end
    end else begin
      rawv[0] = int'(raw_a);
      rawv[1] = int'(raw_b);
      for (int c = 0; c < 2; c++) begin
        if (sy2[c] != 0) begin
          ones[c]++;
          zeros[c] = 0;
        end else begin
          zeros[c]++;
          ones[c] = 0;
        end
        arrm[c] = (pres[c] == 0 && ones[c] == D) ? 1 : 0;
        if (pres[c] != 0 && zeros[c] == D + H) pres[c] = 0;
        else if (arrm[c] != 0)                 pres[c] = 1;
        if (cnt_clr) begin
          cnt8m[c] = arrm[c];
          cnt2m[c] = arrm[c];
        end else if (arrm[c] != 0) begin
          if (cnt8m[c] < 255) cnt8m[c]++;
          if (cnt2m[c] < 3)   cnt2m[c]++;
        end
        sy2[c] = sy1[c];
        sy1[c] = rawv[c];
      end
    end
  end

  // Every cycle outside reset, both instances are compared with the model.
  always @(negedge clk) begin
    if (!rst) begin
      check("flags",    32'({TA, TB, arr_a, arr_b}),     8*pres[0] + 4*pres[1] + 2*arrm[0] + arrm[1]);
      check("flags_w2", 32'({ta2, tb2, arr_a2, arr_b2}), 8*pres[0] + 4*pres[1] + 2*arrm[0] + arrm[1]);
      check("cnt_a",    32'(cnt_a),  cnt8m[0]);
      check("cnt_b",    32'(cnt_b),  cnt8m[1]);
      check("cnt_a_w2", 32'(cnt_a2), cnt2m[0]);
      check("cnt_b_w2", 32'(cnt_b2), cnt2m[1]);
    end
  end

  // ---------------- directed and random stimulus ----------------
  int len[2];
  logic lvl[2];

  initial begin
    raw_a = 1'b0; raw_b = 1'b0; cnt_clr = 1'b0; rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_flags", 32'({TA, TB, arr_a, arr_b}), 0);
    check("rst_cnt",   32'({cnt_a, cnt_b}), 0);
    rst = 1'b0;

    // Assert at edge 0: presence and arrival appear after edge 5.
    raw_a = 1'b1;
    edge_n = -1;
    while (edge_n < 4) step();
    check("a_pre_assert", 32'({TA, arr_a}), 0);
    step();
    check("a_assert",     32'({TA, arr_a}), 3);
    check("a_cnt_first",  32'(cnt_a), 1);
    step();
    check("a_arr_once",   32'({TA, arr_a}), 2);
    // Release captured at edge 20: presence falls after edge 33.
    while (edge_n < 19) step();
    raw_a = 1'b0;
    while (edge_n < 32) step();
    check("a_hold_end", 32'(TA), 1);
    step();
    check("a_released", 32'(TA), 0);

    // Bounce on B: three 2-cycle pulses with 2-cycle gaps.
    for (int i = 0; i < 24; i++) begin
      raw_b = (i < 12) && ((i % 4) < 2);
      step();
      check("bounce", 32'({TB, arr_b, cnt_b}), 0);
    end

    // Gap bridging on A: a 3-cycle gap and a 10-cycle gap are both bridged.
    raw_a = 1'b1;
    repeat (8) step();
    check("gap_start", 32'({TA, cnt_a}), 32'h102);
    for (int i = 0; i < 40; i++) begin
      raw_a = !((i < 3) || (i >= 12 && i < 22));
      step();
      check("gap_ta",  32'({TA, arr_a}), 2);
      check("gap_cnt", 32'(cnt_a), 2);
    end
    raw_a = 1'b0;
    repeat (16) step();
    check("gap_end", 32'(TA), 0);

    // Counter saturation over five full arrivals.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      raw_a = 1'b1;
      repeat (8) step();
      raw_a = 1'b0;
      repeat (16) step();
      check("sat_w2", 32'(cnt_a2), (k > 3) ? 3 : k);
      check("sat_w8", 32'(cnt_a), k);
    end

    // A clear coinciding with an arrival loads 1.
    raw_a = 1'b1;
    repeat (5) step();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("clr_arr",    32'(arr_a), 1);
    check("clr_arr_w8", 32'(cnt_a), 1);
    check("clr_arr_w2", 32'(cnt_a2), 1);
    raw_a = 1'b0;
    repeat (16) step();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("clr_only", 32'({cnt_a, cnt_a2}), 0);

    // Asynchronous reset mid-hold on both channels.
    raw_a = 1'b1; raw_b = 1'b1;
    repeat (8) step();
    raw_a = 1'b0; raw_b = 1'b0;
    repeat (9) step();
    check("pre_rst_hold", 32'({TA, TB}), 3);
    #1 rst = 1'b1;
    raw_a = 1'b1; raw_b = 1'b1;
    #1;
    check("rst_async",    32'({TA, TB, arr_a, arr_b, cnt_a, cnt_b}), 0);
    check("rst_async_w2", 32'({ta2, tb2, arr_a2, arr_b2, cnt_a2, cnt_b2}), 0);
    @(negedge clk);
    rst = 1'b0;
    edge_n = -1;
    while (edge_n < 4) step();
    check("rst_requal_pre", 32'({TA, TB}), 0);
    step();
    check("rst_requal", 32'({TA, TB, arr_a, arr_b}), 15);

    // Randomized independent traffic on both channels, with one reset.
    lvl[0] = raw_a; lvl[1] = raw_b;
    len[0] = 0; len[1] = 0;
    for (int n = 0; n < 4000; n++) begin
      for (int c = 0; c < 2; c++) begin
        if (len[c] == 0) begin
          lvl[c] = !lvl[c];
          len[c] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3))
                                               : int'($urandom_range(4, 24));
        end
        len[c]--;
      end
      raw_a = lvl[0];
      raw_b = lvl[1];
      cnt_clr = ($urandom_range(0, 49) == 0);
      if (n == 2000) begin
        #1 rst = 1'b1;
        #1;
        check("rnd_rst", 32'({TA, TB, arr_a, arr_b, cnt_a, cnt_b}), 0);
        step();
        rst = 1'b0;
      end
      step();
    end
    raw_a = 1'b0; raw_b = 1'b0; cnt_clr = 1'b0;
    repeat (20) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
